nv_nvdla_cacc_slcg_en_ctrl: RTL and testbench

//  Generates the CACC second-level clock-gating enable from datapath activity, with a

---
 rtl/nv_nvdla_cacc_slcg_pkg.sv | 16 +
 rtl/nv_nvdla_cacc_slcg_gcnt.sv | 33 +++
 rtl/nv_nvdla_cacc_slcg_en_ctrl.sv | 122 ++++++++++++
 tb/tb_nv_nvdla_cacc_slcg_en_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_cacc_slcg_pkg.sv
// Shared definitions for the CACC SLCG enable controller.
//   slcg_state_e  : FSM state encoding, also exported on slcg_state_dbg
//   WAKE_CYC_MIN  : smallest usable wake settle length; smaller values are
//                   clamped so clk_rdy can never rise on the enabling edge.
package nv_nvdla_cacc_slcg_pkg;

  typedef enum logic [1:0] {
    ST_WAKE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HYST   = 2'd2,
    ST_GATED  = 2'd3
  } slcg_state_e;

  localparam int WAKE_CYC_MIN = 1;

endpackage

// File: rtl/nv_nvdla_cacc_slcg_gcnt.sv
// Saturating gated-cycle counter.
//   clk, rst_n : clock, async active-low reset
//   inc        : count this cycle (ignored once at all-ones)
//   clr        : clear to zero; takes priority over inc
//   cnt        : current count
module nv_nvdla_cacc_slcg_gcnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/nv_nvdla_cacc_slcg_en_ctrl.sv
// CACC second-level clock-gating enable generator.
// Watches datapath activity, holds clocks on through a programmable idle
// hysteresis, gates them, and on renewed activity re-enables them for a fixed
// settle period before granting clk_rdy.
//   nvdla_core_clk/rstn   : free-running clock, async active-low reset
//   act_src[NUM_ACT]      : per-source busy levels
//   wake_req              : requester wants clocks (held until clk_rdy)
//   reg2dp_slcg_force_on  : keep clocks on
//   reg2dp_slcg_hyst      : idle cycles tolerated before gating
//   gated_cnt_clr         : clear the gated-cycle counter
//   slcg_en_src           : enable to SLCG wrapper (1 = clock runs)
//   clk_rdy               : gated clock stable, traffic allowed
//   dp2reg_slcg_gated_cnt : saturating count of GATED cycles
//   slcg_state_dbg        : current FSM state
module nv_nvdla_cacc_slcg_en_ctrl
  import nv_nvdla_cacc_slcg_pkg::*;
#(
  parameter int NUM_ACT  = 4,
  parameter int HYST_W   = 8,
  parameter int WAKE_CYC = 4,
  parameter int CNT_W    = 32
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic [NUM_ACT-1:0] act_src,
  input  logic               wake_req,
  input  logic               reg2dp_slcg_force_on,
  input  logic [HYST_W-1:0]  reg2dp_slcg_hyst,
  input  logic               gated_cnt_clr,
  output logic               slcg_en_src,
  output logic               clk_rdy,
  output logic [CNT_W-1:0]   dp2reg_slcg_gated_cnt,
  output logic [1:0]         slcg_state_dbg
);

  localparam int WAKE_EFF  = (WAKE_CYC < WAKE_CYC_MIN) ? WAKE_CYC_MIN : WAKE_CYC;
  localparam int WCNT_W    = (WAKE_EFF > 1) ? $clog2(WAKE_EFF) : 1;
  localparam logic [WCNT_W-1:0] WAKE_INIT = WCNT_W'(WAKE_EFF - 1);

  slcg_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [HYST_W-1:0] hcnt_q, hcnt_d;
  logic              en_q, en_d;
  logic              rdy_q, rdy_d;
  logic              busy;

  always_comb begin
    busy    = (|act_src) | wake_req | reg2dp_slcg_force_on;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      // Runs to completion regardless of busy: the requester relies on the
      // full settle time once the enable has gone high.
      ST_WAKE: begin
        if (wcnt_q == '0) state_d = ST_ACTIVE;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      // Hysteresis value is captured only here, so register writes during
      // HYST do not disturb an idle period already in progress.
      ST_ACTIVE: begin
        if (!busy) begin
          if (reg2dp_slcg_hyst == '0) begin
            state_d = ST_GATED;
          end else begin
            hcnt_d  = reg2dp_slcg_hyst;
            state_d = ST_HYST;
          end
        end
      end
      // Busy is tested first so a same-edge wake beats hysteresis expiry.
      ST_HYST: begin
        if (busy)                state_d = ST_ACTIVE;
        else if (hcnt_q <= HYST_W'(1)) state_d = ST_GATED;
        else                     hcnt_d  = hcnt_q - HYST_W'(1);
      end
      ST_GATED: begin
        if (busy) begin
          wcnt_d  = WAKE_INIT;
          state_d = ST_WAKE;
        end
      end
      default: begin
        wcnt_d  = WAKE_INIT;
        state_d = ST_WAKE;
      end
    endcase
    // Outputs are decoded from the next state so they leave the flops
    // aligned with the state register.
    en_d  = (state_d != ST_GATED);
    rdy_d = (state_d == ST_ACTIVE) || (state_d == ST_HYST);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= ST_WAKE;
      wcnt_q  <= WAKE_INIT;
      hcnt_q  <= '0;
      en_q    <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
    end
  end

  nv_nvdla_cacc_slcg_gcnt #(.CNT_W(CNT_W)) u_gcnt (
    .clk   (nvdla_core_clk),
    .rst_n (nvdla_core_rstn),
    .inc   (state_q == ST_GATED),
    .clr   (gated_cnt_clr),
    .cnt   (dp2reg_slcg_gated_cnt)
  );

  assign slcg_en_src    = en_q;
  assign clk_rdy        = rdy_q;
  assign slcg_state_dbg = state_q;

endmodule

// File: tb/tb_nv_nvdla_cacc_slcg_en_ctrl.sv
// Directed bench for the CACC SLCG enable controller. A second instance with a
// 4-bit gated counter shares all inputs so saturation is reachable quickly.
module tb_nv_nvdla_cacc_slcg_en_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  act_src;
  logic        wake_req;
  logic        force_on;
  logic [7:0]  hyst;
  logic        clr;
  logic        en, rdy, en4, rdy4;
  logic [31:0] gcnt;
  logic [3:0]  gcnt4;
  logic [1:0]  st, st4;

  int total = 0;
  int bad   = 0;

  nv_nvdla_cacc_slcg_en_ctrl dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rst_n),
    .act_src               (act_src),
    .wake_req              (wake_req),
    .reg2dp_slcg_force_on  (force_on),
    .reg2dp_slcg_hyst      (hyst),
    .gated_cnt_clr         (clr),
    .slcg_en_src           (en),
    .clk_rdy               (rdy),
    .dp2reg_slcg_gated_cnt (gcnt),
    .slcg_state_dbg        (st)
  );

  nv_nvdla_cacc_slcg_en_ctrl #(.CNT_W(4)) dut4 (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rst_n),
    .act_src               (act_src),
    .wake_req              (wake_req),
    .reg2dp_slcg_force_on  (force_on),
    .reg2dp_slcg_hyst      (hyst),
    .gated_cnt_clr         (clr),
    .slcg_en_src           (en4),
    .clk_rdy               (rdy4),
    .dp2reg_slcg_gated_cnt (gcnt4),
    .slcg_state_dbg        (st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic e_en, input logic e_rdy, input logic [1:0] e_st);
    chk({tag, ".en"},  32'(en),  32'(e_en));
    chk({tag, ".rdy"}, 32'(rdy), 32'(e_rdy));
    chk({tag, ".st"},  32'(st),  32'(e_st));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; act_src = '0; wake_req = 1'b0; force_on = 1'b0;
    hyst = 8'd3; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_st("rst", 1'b1, 1'b0, 2'd0);
    chk("rst.cnt", gcnt, 32'd0);

    // 1: reset release, idle, hyst=3
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      logic [1:0] e_st;
      e_st = (c < 4) ? 2'd0 : (c == 4) ? 2'd1 : (c < 8) ? 2'd2 : 2'd3;
      chk_st($sformatf("t1.c%0d", c), c < 8, (c >= 4) && (c < 8), e_st);
      step();
    end
    chk("t1.cnt1", gcnt, 32'd1);
    step();
    chk("t1.cnt2", gcnt, 32'd2);

    // 4: wake from GATED, drop wake_req mid-WAKE
    wake_req = 1'b1;
    step();
    chk_st("t4.w0", 1'b1, 1'b0, 2'd0);
    chk("t4.cnt", gcnt, 32'd3);
    step();
    chk_st("t4.w1", 1'b1, 1'b0, 2'd0);
    wake_req = 1'b0;
    step();
    chk_st("t4.w2", 1'b1, 1'b0, 2'd0);
    step();
    chk_st("t4.w3", 1'b1, 1'b0, 2'd0);
    step();
    chk_st("t4.act", 1'b1, 1'b1, 2'd1);
    step();
    chk_st("t4.hy", 1'b1, 1'b1, 2'd2);
    step();
    step();
    chk_st("t4.hy3", 1'b1, 1'b1, 2'd2);
    step();
    chk_st("t4.gate", 1'b0, 1'b0, 2'd3);
    chk("t4.cnt2", gcnt, 32'd3);

    // 2: hyst=0 gates on the first idle edge
    act_src = 4'b0001;
    step();
    chk("t2.cnt", gcnt, 32'd4);
    repeat (3) step();
    step();
    chk_st("t2.act", 1'b1, 1'b1, 2'd1);
    hyst = 8'd0;
    step();
    chk_st("t2.act2", 1'b1, 1'b1, 2'd1);
    act_src = 4'b0000;
    step();
    chk_st("t2.gate", 1'b0, 1'b0, 2'd3);
    chk("t2.cnt4", gcnt, 32'd4);
    step();
    chk("t2.cnt5", gcnt, 32'd5);
    step();
    chk("t2.cnt6", gcnt, 32'd6);
    chk("t2.cnt6n", 32'(gcnt4), 32'd6);

    // 5: saturation on the 4-bit counter, clr beats inc
    repeat (12) step();
    chk("t5.wide", gcnt, 32'd18);
    chk("t5.sat", 32'(gcnt4), 32'd15);
    step();
    chk("t5.sat2", 32'(gcnt4), 32'd15);
    clr = 1'b1;
    step();
    chk("t5.clr", gcnt, 32'd0);
    chk("t5.clrn", 32'(gcnt4), 32'd0);
    clr = 1'b0;
    step();
    chk("t5.inc", gcnt, 32'd1);
    chk("t5.incn", 32'(gcnt4), 32'd1);

    // 3: busy at hyst expiry wins; mid-HYST hyst writes ignored
    hyst = 8'd2;
    act_src = 4'b0100;
    step();
    chk("t3.cnt", gcnt, 32'd2);
    repeat (3) step();
    step();
    chk_st("t3.act", 1'b1, 1'b1, 2'd1);
    act_src = 4'b0000;
    step();
    chk_st("t3.hy2", 1'b1, 1'b1, 2'd2);
    step();
    chk_st("t3.hy1", 1'b1, 1'b1, 2'd2);
    act_src = 4'b0100;
    step();
    chk_st("t3.race", 1'b1, 1'b1, 2'd1);
    chk("t3.cnt2", gcnt, 32'd2);
    act_src = 4'b0000;
    step();
    hyst = 8'd9;
    step();
    chk_st("t3.hyx", 1'b1, 1'b1, 2'd2);
    step();
    chk_st("t3.gate", 1'b0, 1'b0, 2'd3);

    // 6: reset mid-GATED and mid-HYST
    rst_n = 1'b0;
    #1;
    chk_st("t6.rg", 1'b1, 1'b0, 2'd0);
    chk("t6.cnt", gcnt, 32'd0);
    rst_n = 1'b1;
    hyst = 8'd3;
    repeat (4) step();
    chk_st("t6.act", 1'b1, 1'b1, 2'd1);
    step();
    chk_st("t6.hy", 1'b1, 1'b1, 2'd2);
    rst_n = 1'b0;
    #1;
    chk_st("t6.rh", 1'b1, 1'b0, 2'd0);
    rst_n = 1'b1;

    // force_on pins ACTIVE after WAKE completes
    force_on = 1'b1;
    repeat (3) step();
    chk_st("fo.wake", 1'b1, 1'b0, 2'd0);
    step();
    repeat (6) step();
    chk_st("fo.pin", 1'b1, 1'b1, 2'd1);
    force_on = 1'b0;
    step();
    chk_st("fo.rel", 1'b1, 1'b1, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
